// File: rtl/core_ctrl_fsm.sv
// Purpose : multi-cycle core sequencer; owns PC, runs fetch/LSU handshakes, serialises trap CSR writes, gates arch writes.
// Latency : ALU op 2 cycles (fetch w/ same-cycle data + EXEC), load/store 2 + LSU latency, ecall 4 cycles.
// Backpres: imem_valid_o held until imem_ready_i, lsu_req_o held until lsu_done_i; stalls indefinitely on either.
//
// Optional feature macro: CORE_CTRL_ILLEGAL_TRAP_EN
//   defined   -> illegal instruction traps (mcause=2) instead of halting
//   undefined -> illegal instruction enters HALT and raises halted_o
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   imem_*                      fetch request (addr/valid/ready) and response (rdata/valid/ready)
//   inst_o                      latched instruction for the combinational IDU
//   is_load_i .. inst_invalid_i decode class from IDU
//   reg_write_en_i, exu_csr_*   EXU write requests (gated here)
//   next_pc_i                   EXU computed next PC / mtvec, sampled in the commit cycle only
//   lsu_req_o, lsu_done_i       load/store handshake
//   gpr_we_o, wb_sel_load_o     register-file write enable and writeback mux select
//   csr_we_o/waddr_o/wdata_o    single CSR write port
//   pc_o, commit_o, retired_o   architectural PC, retire pulse, retired count
//   halted_o                    sticky halt flag
module core_ctrl_fsm #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = 'h8000_0000,
  parameter int               CNT_W       = 64,
  parameter logic [11:0]      MCAUSE_ADDR = 12'h342,
  parameter logic [11:0]      MEPC_ADDR   = 12'h341
) (
  input  logic              clk,
  input  logic              rst,
  output logic [XLEN-1:0]   imem_addr_o,
  output logic              imem_valid_o,
  input  logic              imem_ready_i,
  input  logic [31:0]       imem_rdata_i,
  input  logic              imem_rdata_valid_i,
  output logic              imem_rdata_ready_o,
  output logic [31:0]       inst_o,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic              is_ecall_i,
  input  logic              inst_invalid_i,
  input  logic              reg_write_en_i,
  input  logic              exu_csr_we_i,
  input  logic [11:0]       exu_csr_addr_i,
  input  logic [XLEN-1:0]   exu_csr_wdata_i,
  input  logic [XLEN-1:0]   next_pc_i,
  output logic              lsu_req_o,
  input  logic              lsu_done_i,
  output logic              gpr_we_o,
  output logic              wb_sel_load_o,
  output logic              csr_we_o,
  output logic [11:0]       csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              commit_o,
  output logic [CNT_W-1:0]  retired_o,
  output logic              halted_o
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    MEM,
    TRAP_EPC,
    TRAP_CAUSE,
    HALT
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [CNT_W-1:0]  retired_q;
  logic              halted_q, halted_d;

`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
  // Remembers whether the trap in flight came from an illegal instruction
  // (mcause 2) or from ecall (mcause 11).
  logic              cause_ill_q, cause_ill_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      retired_q <= '0;
      halted_q  <= 1'b0;
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
      cause_ill_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      halted_q <= halted_d;
      if (commit_o) begin
        retired_q <= retired_q + CNT_W'(1);
      end
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
      cause_ill_q <= cause_ill_d;
`endif
    end
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    inst_d             = inst_q;
    halted_d           = halted_q;
    imem_valid_o       = 1'b0;
    imem_rdata_ready_o = 1'b0;
    lsu_req_o          = 1'b0;
    gpr_we_o           = 1'b0;
    wb_sel_load_o      = 1'b0;
    csr_we_o           = 1'b0;
    csr_waddr_o        = '0;
    csr_wdata_o        = '0;
    commit_o           = 1'b0;
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
    cause_ill_d        = cause_ill_q;
`endif

    case (state_q)
      FETCH_REQ: begin
        imem_valid_o = 1'b1;
        if (imem_ready_i) begin
          if (imem_rdata_valid_i) begin
            // Zero-wait memory: the response rides along with the accept,
            // so acknowledge it here and skip FETCH_WAIT.
            imem_rdata_ready_o = 1'b1;
            inst_d             = imem_rdata_i;
            state_d            = EXEC;
          end else begin
            state_d = FETCH_WAIT;
          end
        end
      end

      FETCH_WAIT: begin
        imem_rdata_ready_o = 1'b1;
        if (imem_rdata_valid_i) begin
          inst_d  = imem_rdata_i;
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (inst_invalid_i) begin
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
          cause_ill_d = 1'b1;
          state_d     = TRAP_EPC;
`else
          halted_d = 1'b1;
          state_d  = HALT;
`endif
        end else if (is_ecall_i) begin
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
          cause_ill_d = 1'b0;
`endif
          state_d = TRAP_EPC;
        end else if (is_load_i || is_store_i) begin
          state_d = MEM;
        end else begin
          gpr_we_o    = reg_write_en_i;
          csr_we_o    = exu_csr_we_i;
          // Address/data only leave the block alongside a real write.
          if (exu_csr_we_i) begin
            csr_waddr_o = exu_csr_addr_i;
            csr_wdata_o = exu_csr_wdata_i;
          end
          commit_o = 1'b1;
          pc_d     = next_pc_i;
          state_d  = FETCH_REQ;
        end
      end

      MEM: begin
        lsu_req_o = 1'b1;
        if (lsu_done_i) begin
          // Stores never write the GPR file even if the EXU asks.
          gpr_we_o      = is_load_i & reg_write_en_i;
          wb_sel_load_o = 1'b1;
          commit_o      = 1'b1;
          pc_d          = next_pc_i;
          state_d       = FETCH_REQ;
        end
      end

      TRAP_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = MEPC_ADDR;
        csr_wdata_o = pc_q;
        state_d     = TRAP_CAUSE;
      end

      TRAP_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = MCAUSE_ADDR;
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
        csr_wdata_o = cause_ill_q ? XLEN'(2) : XLEN'(11);
`else
        csr_wdata_o = XLEN'(11);
`endif
        // next_pc_i carries mtvec from the EXU during a trap.
        commit_o = 1'b1;
        pc_d     = next_pc_i;
        state_d  = FETCH_REQ;
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = FETCH_REQ;
      end
    endcase
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign inst_o      = inst_q;
  assign retired_o   = retired_q;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Purpose : directed bench for core_ctrl_fsm with a commit scoreboard.
// Latency : n/a (testbench).
// Backpres: n/a (testbench).
module tb_core_ctrl_fsm;

  localparam int          XLEN = 32;
  localparam int          CW   = 3;
  localparam logic [31:0] RPC  = 32'h8000_0000;

  logic              clk;
  logic              rst;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_valid;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic              imem_rdata_valid;
  logic              imem_rdata_ready;
  logic [31:0]       inst;
  logic              is_load, is_store, is_ecall, inst_invalid;
  logic              reg_write_en;
  logic              exu_csr_we;
  logic [11:0]       exu_csr_addr;
  logic [XLEN-1:0]   exu_csr_wdata;
  logic [XLEN-1:0]   next_pc;
  logic              lsu_req;
  logic              lsu_done;
  logic              gpr_we;
  logic              wb_sel_load;
  logic              csr_we;
  logic [11:0]       csr_waddr;
  logic [XLEN-1:0]   csr_wdata;
  logic [XLEN-1:0]   pc;
  logic              commit;
  logic [CW-1:0]     retired;
  logic              halted;

  core_ctrl_fsm #(
    .XLEN(XLEN), .RESET_PC(RPC), .CNT_W(CW),
    .MCAUSE_ADDR(12'h342), .MEPC_ADDR(12'h341)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr_o(imem_addr), .imem_valid_o(imem_valid), .imem_ready_i(imem_ready),
    .imem_rdata_i(imem_rdata), .imem_rdata_valid_i(imem_rdata_valid),
    .imem_rdata_ready_o(imem_rdata_ready), .inst_o(inst),
    .is_load_i(is_load), .is_store_i(is_store), .is_ecall_i(is_ecall),
    .inst_invalid_i(inst_invalid), .reg_write_en_i(reg_write_en),
    .exu_csr_we_i(exu_csr_we), .exu_csr_addr_i(exu_csr_addr),
    .exu_csr_wdata_i(exu_csr_wdata), .next_pc_i(next_pc),
    .lsu_req_o(lsu_req), .lsu_done_i(lsu_done),
    .gpr_we_o(gpr_we), .wb_sel_load_o(wb_sel_load),
    .csr_we_o(csr_we), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
    .pc_o(pc), .commit_o(commit), .retired_o(retired), .halted_o(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc_new;
    logic          gpr_we;
    logic          wb_sel;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  logic [31:0]   exp_pc  = RPC;
  logic [CW-1:0] exp_ret = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the active edge; outputs checked 1 later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_commit(input logic [31:0] npc, input logic g, input logic w);
    exp_ret = exp_ret + 1'b1;
    exp_pc  = npc;
    sb.push_back('{pc_new: npc, gpr_we: g, wb_sel: w, ret: exp_ret});
  endtask

  // Fetch with zero-wait memory: accept and data in the same cycle.
  task automatic fetch_now(input logic [31:0] instr);
    imem_ready = 1'b1; imem_rdata_valid = 1'b1; imem_rdata = instr;
    #1;
    chk("fetch_valid", imem_valid, 1);
    chk("fetch_addr", imem_addr, exp_pc);
    cyc();
    imem_ready = 1'b0; imem_rdata_valid = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic alu(input logic [31:0] instr, input logic [31:0] npc);
    fetch_now(instr);
    reg_write_en = 1'b1; next_pc = npc;
    push_commit(npc, 1'b1, 1'b0);
    #1;
    chk("alu_inst", inst, instr);
    chk("alu_commit", commit, 1);
    chk("alu_gpr_we", gpr_we, 1);
    cyc();
    reg_write_en = 1'b0;
    #1;
    chk("alu_pc", pc, exp_pc);
    chk("alu_retired", retired, exp_ret);
  endtask

  // Scoreboard: every commit must match the oldest expected retire.
  always @(negedge clk) begin
    if (!rst && commit) begin
      exp_t e;
      chk("sb_expected_commit", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_gpr_we", gpr_we, e.gpr_we);
        chk("sb_wb_sel", wb_sel_load, e.wb_sel);
        @(posedge clk);
        #1;
        chk("sb_pc", pc, e.pc_new);
        chk("sb_retired", retired, e.ret);
      end
    end
  end

  initial begin
    rst = 1'b1;
    imem_ready = 0; imem_rdata = 0; imem_rdata_valid = 0;
    is_load = 0; is_store = 0; is_ecall = 0; inst_invalid = 0;
    reg_write_en = 0; exu_csr_we = 0; exu_csr_addr = 0; exu_csr_wdata = 0;
    next_pc = 0; lsu_done = 0;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_imem_valid", imem_valid, 1);
    chk("rst_rdata_ready", imem_rdata_ready, 0);
    chk("rst_lsu_req", lsu_req, 0);
    chk("rst_commit", commit, 0);
    chk("rst_csr_we", csr_we, 0);
    chk("rst_gpr_we", gpr_we, 0);

    // ADDI, zero-wait fetch: commit in cycle 2.
    alu(32'h0010_0093, 32'h8000_0004);

    // Delayed fetch: ready after 3 cycles, data 2 cycles later.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dly_valid_held", imem_valid, 1);
      chk("dly_no_commit", commit, 0);
      cyc();
    end
    imem_ready = 1'b1;
    #1;
    chk("dly_valid_accept", imem_valid, 1);
    cyc();
    imem_ready = 1'b0; imem_rdata = 32'hdead_beef;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("dly_wait_valid", imem_valid, 0);
      chk("dly_wait_rdy", imem_rdata_ready, 1);
      chk("dly_inst_stable", inst, 32'h0010_0093);
      cyc();
    end
    imem_rdata_valid = 1'b1; imem_rdata = 32'h0020_81b3;
    cyc();
    imem_rdata_valid = 1'b0; imem_rdata = 32'hdead_beef;
    reg_write_en = 1'b1; next_pc = 32'h8000_0008;
    push_commit(32'h8000_0008, 1'b1, 1'b0);
    #1;
    chk("dly_inst", inst, 32'h0020_81b3);
    chk("dly_commit", commit, 1);
    cyc();
    reg_write_en = 1'b0; imem_rdata = 32'h0;
    #1;
    chk("dly_retired", retired, exp_ret);

    // Load, lsu_done after 4 cycles.
    fetch_now(32'h0000_a103);
    is_load = 1'b1; reg_write_en = 1'b1; next_pc = 32'h8000_000c;
    #1;
    chk("ld_exec_lsu_req", lsu_req, 0);
    chk("ld_exec_commit", commit, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_req_held", lsu_req, 1);
      chk("ld_gpr_we_early", gpr_we, 0);
      chk("ld_wb_sel_early", wb_sel_load, 0);
      cyc();
    end
    lsu_done = 1'b1;
    push_commit(32'h8000_000c, 1'b1, 1'b1);
    #1;
    chk("ld_req_done", lsu_req, 1);
    chk("ld_gpr_we", gpr_we, 1);
    chk("ld_wb_sel", wb_sel_load, 1);
    chk("ld_commit", commit, 1);
    cyc();
    lsu_done = 1'b0; is_load = 1'b0; reg_write_en = 1'b0;
    #1;
    chk("ld_req_drop", lsu_req, 0);
    chk("ld_pc", pc, 32'h8000_000c);

    // Store with a spurious EXU write request: GPR write must stay gated.
    fetch_now(32'h0020_a023);
    is_store = 1'b1; reg_write_en = 1'b1; next_pc = 32'h8000_0010;
    cyc();
    lsu_done = 1'b1;
    push_commit(32'h8000_0010, 1'b0, 1'b1);
    #1;
    chk("st_gpr_we", gpr_we, 0);
    chk("st_commit", commit, 1);
    cyc();
    lsu_done = 1'b0; is_store = 1'b0; reg_write_en = 1'b0;

    // ecall at 0x8000_0010, mtvec 0x8000_0100.
    fetch_now(32'h0000_0073);
    is_ecall = 1'b1; next_pc = 32'h8000_0100;
    #1;
    chk("ec_exec_csr_we", csr_we, 0);
    chk("ec_exec_commit", commit, 0);
    cyc();
    #1;
    chk("ec_epc_we", csr_we, 1);
    chk("ec_epc_addr", csr_waddr, 12'h341);
    chk("ec_epc_data", csr_wdata, 32'h8000_0010);
    chk("ec_epc_commit", commit, 0);
    cyc();
    push_commit(32'h8000_0100, 1'b0, 1'b0);
    #1;
    chk("ec_cause_we", csr_we, 1);
    chk("ec_cause_addr", csr_waddr, 12'h342);
    chk("ec_cause_data", csr_wdata, 11);
    chk("ec_cause_commit", commit, 1);
    cyc();
    is_ecall = 1'b0;
    #1;
    chk("ec_csr_we_off", csr_we, 0);
    chk("ec_pc", pc, 32'h8000_0100);

    // CSR write from EXU on a plain op.
    fetch_now(32'h3050_90f3);
    exu_csr_we = 1'b1; exu_csr_addr = 12'h305; exu_csr_wdata = 32'h1234_5678;
    reg_write_en = 1'b1; next_pc = 32'h8000_0104;
    push_commit(32'h8000_0104, 1'b1, 1'b0);
    #1;
    chk("csr_we", csr_we, 1);
    chk("csr_addr", csr_waddr, 12'h305);
    chk("csr_data", csr_wdata, 32'h1234_5678);
    cyc();
    exu_csr_we = 1'b0; reg_write_en = 1'b0;

    // Two more retires: the 3-bit counter wraps 7 -> 0.
    alu(32'h0010_0093, 32'h8000_0108);
    alu(32'h0010_0093, 32'h8000_010c);
    chk("wrap_retired_zero", retired, 0);

    // Reset mid-MEM; a late lsu_done afterwards must be ignored.
    fetch_now(32'h0000_a103);
    is_load = 1'b1; reg_write_en = 1'b1; next_pc = 32'h8000_0110;
    cyc();
    #1;
    chk("rstm_req", lsu_req, 1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; lsu_done = 1'b1; is_load = 1'b0; reg_write_en = 1'b0;
    exp_pc = RPC; exp_ret = '0;
    #1;
    chk("rstm_lsu_req", lsu_req, 0);
    chk("rstm_pc", pc, RPC);
    chk("rstm_retired", retired, 0);
    chk("rstm_inst", inst, 32'h0000_0013);
    chk("rstm_commit", commit, 0);
    chk("rstm_imem_valid", imem_valid, 1);
    cyc();
    lsu_done = 1'b0;

    // Illegal instruction (ecall also raised: invalid has priority).
    fetch_now(32'hffff_ffff);
    inst_invalid = 1'b1; is_ecall = 1'b1; next_pc = 32'h8000_0200;
    #1;
    chk("ill_exec_commit", commit, 0);
    cyc();
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
    #1;
    chk("ill_epc_we", csr_we, 1);
    chk("ill_epc_addr", csr_waddr, 12'h341);
    chk("ill_epc_data", csr_wdata, RPC);
    cyc();
    push_commit(32'h8000_0200, 1'b0, 1'b0);
    #1;
    chk("ill_cause_addr", csr_waddr, 12'h342);
    chk("ill_cause_data", csr_wdata, 2);
    chk("ill_cause_commit", commit, 1);
    cyc();
    inst_invalid = 1'b0; is_ecall = 1'b0;
    #1;
    chk("ill_halted", halted, 0);
    chk("ill_pc", pc, 32'h8000_0200);
`else
    inst_invalid = 1'b0; is_ecall = 1'b0;
    imem_ready = 1'b1; imem_rdata_valid = 1'b1; imem_rdata = 32'h0010_0093;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_flag", halted, 1);
      chk("halt_imem_valid", imem_valid, 0);
      chk("halt_rdata_ready", imem_rdata_ready, 0);
      chk("halt_commit", commit, 0);
      chk("halt_csr_we", csr_we, 0);
      cyc();
    end
    imem_ready = 1'b0; imem_rdata_valid = 1'b0;
    #1;
    chk("halt_pc", pc, RPC);
    chk("halt_retired", retired, 0);
`endif

    repeat (3) cyc();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
